// File: rtl/uart_bus_pkg.sv
// Shared types and constants for the UART bus initiator.
package uart_bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StTx,
        StRx,
        StRxCap,
        StGap
    } state_e;

    // Word offsets of the UART slave registers relative to BASE_ADDR.
    localparam logic [31:0] REG_DATA = 32'd0;
    localparam logic [31:0] REG_DIV  = 32'd1;
    localparam logic [31:0] REG_THRU = 32'd2;

    // Data-register read: this bit set means the byte in [7:0] is real.
    localparam int unsigned RX_VALID_BIT = 8;

endpackage

// File: rtl/uart_bus_arbiter.sv
// Picks the next bus cycle in IDLE: config first, then RX/TX alternating on contention.
module uart_bus_arbiter (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic idle_i,
    input  logic cfg_pending_i,
    input  logic tx_valid_i,
    input  logic rx_valid_i,
    input  logic rx_irq_i,
    input  logic poll_zero_i,
    output logic grant_cfg_o,
    output logic grant_tx_o,
    output logic grant_rx_o
);

    logic last_rx_q, last_rx_d;
    logic rx_elig, tx_elig;

    // Eligibility, priority and fairness; last_rx remembers the last data cycle type.
    always_comb begin
        grant_cfg_o = 1'b0;
        grant_tx_o  = 1'b0;
        grant_rx_o  = 1'b0;
        last_rx_d   = last_rx_q;
        // Single-entry RX buffer: never read while a byte is still waiting for the client.
        rx_elig     = !rx_valid_i && (rx_irq_i || poll_zero_i);
        tx_elig     = tx_valid_i;
        if (idle_i) begin
            if (cfg_pending_i) begin
                grant_cfg_o = 1'b1;
            end else if (rx_elig && tx_elig) begin
                grant_tx_o = last_rx_q;
                grant_rx_o = !last_rx_q;
            end else if (rx_elig) begin
                grant_rx_o = 1'b1;
            end else if (tx_elig) begin
                grant_tx_o = 1'b1;
            end
        end
        if (grant_rx_o) begin
            last_rx_d = 1'b1;
        end else if (grant_tx_o) begin
            last_rx_d = 1'b0;
        end
    end

    // Fairness flop.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            last_rx_q <= 1'b0;
        end else begin
            last_rx_q <= last_rx_d;
        end
    end

endmodule

// File: rtl/uart_bus_initiator.sv
// Bus master that streams bytes to/from the UART slave port via valid/ready.
// Optional ack timeout is compiled in with `define UART_INIT_TIMEOUT_EN.
module uart_bus_initiator
    import uart_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned POLL_INTERVAL  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [15:0] cfg_divisor,
    input  logic        cfg_wr,
    output logic        cfg_busy,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_we_o,
    output logic        m_stb_o,
    input  logic        m_ack_i,
    input  logic        rx_irq_i,
    output logic        rx_iack_o,
    output logic        err_o
);

    localparam logic [31:0] POLL_RELOAD = 32'(POLL_INTERVAL - 1);

    state_e      state_q, state_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        tx_ready_q, tx_ready_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        cfg_busy_q, cfg_busy_d;
    logic [15:0] cfg_div_q, cfg_div_d;
    logic [31:0] poll_q, poll_d;
    logic        grant_cfg, grant_tx, grant_rx;
    logic        unused_dat;

    assign unused_dat = ^m_dat_i[31:RX_VALID_BIT+1];

`ifdef UART_INIT_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] wait_q, wait_d;
    logic        err_q, err_d;
`else
    logic        unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    uart_bus_arbiter u_arbiter (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .idle_i        (state_q == StIdle),
        .cfg_pending_i (cfg_busy_q),
        .tx_valid_i    (tx_valid),
        .rx_valid_i    (rx_valid_q),
        .rx_irq_i      (rx_irq_i),
        .poll_zero_i   (poll_q == '0),
        .grant_cfg_o   (grant_cfg),
        .grant_tx_o    (grant_tx),
        .grant_rx_o    (grant_rx)
    );

    // Next-state: bus cycle sequencing, RX buffer, config latch and poll counter.
    always_comb begin
        state_d    = state_q;
        stb_d      = stb_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        tx_ready_d = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        cfg_busy_d = cfg_busy_q;
        cfg_div_d  = cfg_div_q;
        poll_d     = (poll_q != '0) ? poll_q - 32'd1 : '0;
`ifdef UART_INIT_TIMEOUT_EN
        wait_d     = '0;
        err_d      = err_q;
`endif
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (grant_cfg) begin
                    state_d = StCfg;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = BASE_ADDR + REG_DIV;
                    dat_d   = {16'h0, cfg_div_q};
                end else if (grant_rx) begin
                    state_d = StRx;
                    stb_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = BASE_ADDR + REG_DATA;
                    dat_d   = '0;
                end else if (grant_tx) begin
                    // Byte captured now; tx_ready confirms the handshake next cycle.
                    state_d    = StTx;
                    stb_d      = 1'b1;
                    we_d       = 1'b1;
                    adr_d      = BASE_ADDR + REG_DATA;
                    dat_d      = {24'h0, tx_data};
                    tx_ready_d = 1'b1;
                end
            end
            StCfg: begin
                if (m_ack_i) begin
                    state_d    = StGap;
                    stb_d      = 1'b0;
                    we_d       = 1'b0;
                    cfg_busy_d = 1'b0;
                end
            end
            StTx: begin
                if (m_ack_i) begin
                    state_d = StGap;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                end
            end
            StRx: begin
                if (m_ack_i) begin
                    state_d = StRxCap;
                    stb_d   = 1'b0;
                end
            end
            StRxCap: begin
                // Responder registers read data, so it is valid one cycle after ack.
                if (m_dat_i[RX_VALID_BIT]) begin
                    rx_data_d  = m_dat_i[7:0];
                    rx_valid_d = 1'b1;
                end
                poll_d  = POLL_RELOAD;
                state_d = StGap;
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                stb_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase

`ifdef UART_INIT_TIMEOUT_EN
        if ((state_q == StCfg || state_q == StTx || state_q == StRx) && !m_ack_i) begin
            if (wait_q == TIMEOUT_LAST) begin
                state_d = StGap;
                stb_d   = 1'b0;
                we_d    = 1'b0;
                err_d   = 1'b1;
                if (state_q == StCfg) begin
                    cfg_busy_d = 1'b0;
                end
            end else begin
                wait_d = wait_q + 32'd1;
            end
        end
`endif

        // A new request wins over completion of the one in flight.
        if (cfg_wr) begin
            cfg_div_d  = cfg_divisor;
            cfg_busy_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= StIdle;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            tx_ready_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cfg_busy_q <= 1'b0;
            cfg_div_q  <= '0;
            poll_q     <= POLL_RELOAD;
        end else begin
            state_q    <= state_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cfg_busy_q <= cfg_busy_d;
            cfg_div_q  <= cfg_div_d;
            poll_q     <= poll_d;
        end
    end

`ifdef UART_INIT_TIMEOUT_EN
    // Ack-wait counter and sticky error flag.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign m_stb_o   = stb_q;
    assign m_we_o    = we_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = dat_q;
    assign tx_ready  = tx_ready_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign cfg_busy  = cfg_busy_q;
    assign rx_iack_o = (state_q == StRx);

endmodule

// File: tb/tb_uart_bus_initiator.sv
// Directed + randomized bench for uart_bus_initiator with a behavioural bus responder.
module tb_uart_bus_initiator;

    localparam logic [31:0] BASE = 32'h100;
    localparam int P  = 16;
    localparam int TO = 64;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [15:0] cfg_divisor = '0;
    logic        cfg_wr = 1'b0;
    logic        cfg_busy;
    logic [31:0] m_adr_o, m_dat_o;
    logic [31:0] m_dat_i = '0;
    logic        m_we_o, m_stb_o;
    logic        m_ack_i = 1'b0;
    logic        rx_irq_i = 1'b0;
    logic        rx_iack_o, err_o;

    uart_bus_initiator #(
        .BASE_ADDR      (BASE),
        .POLL_INTERVAL  (P),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .cfg_divisor (cfg_divisor),
        .cfg_wr      (cfg_wr),
        .cfg_busy    (cfg_busy),
        .m_adr_o     (m_adr_o),
        .m_dat_o     (m_dat_o),
        .m_dat_i     (m_dat_i),
        .m_we_o      (m_we_o),
        .m_stb_o     (m_stb_o),
        .m_ack_i     (m_ack_i),
        .rx_irq_i    (rx_irq_i),
        .rx_iack_o   (rx_iack_o),
        .err_o       (err_o)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Responder configuration and logs.
    bit          ack_en = 1'b1;
    bit          rand_lat = 1'b0;
    int          ack_lat = 0;
    logic [31:0] rd_q[$];
    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];
    bit          seq_q[$];
    int          rd_rise_q[$];
    logic [7:0]  rx_got_q[$];
    int          rd_cnt = 0;
    int          stab_bad = 0, gap_bad = 0, iack_bad = 0, iack_seen = 0;
    int          last_run = 0;

    // Responder, evaluated mid-cycle; ack and read data are stable for the next posedge.
    int          cyc = 0, run = 0, cur_lat = 0;
    bit          gap_pending = 1'b0, prev_ack;
    logic [31:0] s_adr, s_dat;
    logic        s_we;
    always @(negedge sys_clk) begin
        cyc++;
        prev_ack    = gap_pending;
        gap_pending = 1'b0;
        if (rx_valid && rx_ready) rx_got_q.push_back(rx_data);
        if (m_stb_o) begin
            if (run == 0) begin
                s_adr = m_adr_o; s_dat = m_dat_o; s_we = m_we_o;
                cur_lat = rand_lat ? int'($urandom_range(0, 3)) : ack_lat;
                if (prev_ack) gap_bad++;
                if (!m_we_o) rd_rise_q.push_back(cyc);
            end else if (m_adr_o !== s_adr || m_dat_o !== s_dat || m_we_o !== s_we) begin
                stab_bad++;
            end
            if (m_we_o && rx_iack_o) iack_bad++;
            m_ack_i = ack_en && (run >= cur_lat);
            run++;
            if (m_ack_i) begin
                seq_q.push_back(m_we_o);
                if (m_we_o) begin
                    wr_adr_q.push_back(m_adr_o);
                    wr_dat_q.push_back(m_dat_o);
                end else begin
                    if (rx_iack_o) iack_seen++; else iack_bad++;
                    m_dat_i = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
                    rd_cnt++;
                end
                last_run    = run;
                run         = 0;
                gap_pending = 1'b1;
            end
        end else begin
            m_ack_i = 1'b0;
            if (run != 0) last_run = run;
            run = 0;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && t < 400) begin tick(); t++; end
        check("tx_handshake_in_time", 32'(t < 400), 32'd1);
        tick();
        tx_valid = 1'b0;
    endtask

    // Compare the write log with the expected byte stream; every byte is one data-register write.
    task automatic check_writes(input logic [7:0] exp_q[$]);
        int t;
        t = 0;
        while (wr_dat_q.size() < exp_q.size() && t < 500) begin tick(); t++; end
        check("tx_write_count", wr_dat_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_dat_q.size(); i++) begin
            check("tx_write_adr", wr_adr_q[i], BASE);
            check("tx_write_dat", wr_dat_q[i], {24'h0, exp_q[i]});
        end
        wr_adr_q.delete();
        wr_dat_q.delete();
    endtask

    initial begin
        logic [7:0]  exp_tx[$];
        logic [7:0]  exp_rx[$];
        logic [31:0] v;
        int          t, snap, alt_bad;

        // Reset values.
        repeat (3) tick();
        check("rst_stb", m_stb_o, 0);
        check("rst_we", m_we_o, 0);
        check("rst_adr", m_adr_o, 0);
        check("rst_dat", m_dat_o, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_cfg_busy", cfg_busy, 0);
        check("rst_iack", rx_iack_o, 0);
        check("rst_err", err_o, 0);
        sys_rst = 1'b0;
        tick();

        // Divisor write.
        cfg_divisor = 16'h0036;
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        check("cfg_busy_set", cfg_busy, 1);
        t = 0;
        while (cfg_busy && t < 100) begin tick(); t++; end
        check("cfg_busy_clear", cfg_busy, 0);
        check("cfg_write_count", wr_dat_q.size(), 1);
        if (wr_dat_q.size() != 0) begin
            check("cfg_write_adr", wr_adr_q[0], BASE + 32'd1);
            check("cfg_write_dat", wr_dat_q[0], 32'h36);
        end
        wr_adr_q.delete();
        wr_dat_q.delete();

        // Fixed stream, ack after two strobe cycles.
        ack_lat = 2;
        exp_tx = '{8'h41, 8'h42, 8'h43};
        foreach (exp_tx[i]) send_byte(exp_tx[i]);
        check_writes(exp_tx);

        // Random stream with random ack latency.
        rand_lat = 1'b1;
        exp_tx.delete();
        for (int i = 0; i < 8; i++) exp_tx.push_back(8'($urandom));
        foreach (exp_tx[i]) send_byte(exp_tx[i]);
        check_writes(exp_tx);
        rand_lat = 1'b0;
        ack_lat  = 0;

        // Interrupt-driven read; buffer holds until consumed and blocks further reads.
        rd_q.push_back(32'h155);
        rx_irq_i = 1'b1;
        t = 0;
        while (!rx_valid && t < 100) begin tick(); t++; end
        check("irq_rx_valid", rx_valid, 1);
        check("irq_rx_data", rx_data, 8'h55);
        snap = rd_cnt;
        repeat (40) tick();
        check("rx_buffer_blocks_reads", rd_cnt, snap);
        check("rx_data_held", rx_data, 8'h55);
        rx_irq_i = 1'b0;
        rx_ready = 1'b1;
        tick();
        check("rx_valid_consumed", rx_valid, 0);
        repeat (4) tick();
        rx_got_q.delete();

        // Random reads: only responses with bit 8 set reach the client.
        exp_rx.delete();
        for (int i = 0; i < 10; i++) begin
            v = $urandom;
            rd_q.push_back(v);
            if (v[8]) exp_rx.push_back(v[7:0]);
        end
        rx_irq_i = 1'b1;
        t = 0;
        while (rd_q.size() != 0 && t < 500) begin tick(); t++; end
        repeat (6) tick();
        rx_irq_i = 1'b0;
        check("rx_byte_count", rx_got_q.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size() && i < rx_got_q.size(); i++)
            check("rx_byte", rx_got_q[i], exp_rx[i]);

        // Empty polls: reload on capture, count P-1 down to 0, read one cycle later;
        // with a same-cycle ack consecutive strobe rises are P+2 cycles apart.
        repeat (4) tick();
        rd_rise_q.delete();
        t = 0;
        while (rd_rise_q.size() < 3 && t < 200) begin tick(); t++; end
        check("poll_reads_seen", 32'(rd_rise_q.size() >= 3), 1);
        if (rd_rise_q.size() >= 3)
            check("poll_interval", rd_rise_q[2] - rd_rise_q[1], P + 2);
        check("poll_empty_no_rx", rx_valid, 0);

        // Contention: data cycles must alternate between reads and writes.
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        rx_irq_i = 1'b1;
        seq_q.delete();
        repeat (150) tick();
        tx_valid = 1'b0;
        rx_irq_i = 1'b0;
        alt_bad = 0;
        for (int i = 3; i < seq_q.size(); i++) if (seq_q[i] == seq_q[i-1]) alt_bad++;
        check("alt_enough_cycles", 32'(seq_q.size() >= 12), 1);
        check("alt_violations", alt_bad, 0);
        repeat (10) tick();
        wr_adr_q.delete();
        wr_dat_q.delete();

`ifdef UART_INIT_TIMEOUT_EN
        // Missing ack: strobe held exactly TO cycles, then sticky error.
        ack_en = 1'b0;
        send_byte(8'h99);
        t = 0;
        while (m_stb_o && t < TO + 20) begin tick(); t++; end
        tick();
        check("timeout_stb_cycles", last_run, TO);
        check("timeout_err", err_o, 1);
        repeat (3) tick();
        check("timeout_err_sticky", err_o, 1);
        ack_en = 1'b1;
        repeat (4) tick();
`else
        check("err_tied_low", err_o, 0);
`endif

        // Reset mid-TX with a pending config request and a buffered RX byte.
        rx_ready = 1'b0;
        rd_q.push_back(32'h1AA);
        rx_irq_i = 1'b1;
        t = 0;
        while (!rx_valid && t < 200) begin tick(); t++; end
        rx_irq_i = 1'b0;
        check("pre_rst_rx_valid", rx_valid, 1);
        ack_en = 1'b0;
        send_byte(8'h77);
        cfg_divisor = 16'h1234;
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        repeat (2) tick();
        check("pre_rst_stb", m_stb_o, 1);
        #2 sys_rst = 1'b1;
        #1;
        check("async_rst_stb", m_stb_o, 0);
        check("async_rst_we", m_we_o, 0);
        check("async_rst_adr", m_adr_o, 0);
        check("async_rst_dat", m_dat_o, 0);
        check("async_rst_rx_valid", rx_valid, 0);
        check("async_rst_rx_data", rx_data, 0);
        check("async_rst_cfg_busy", cfg_busy, 0);
        check("async_rst_iack", rx_iack_o, 0);
        check("async_rst_err", err_o, 0);
        #2 sys_rst = 1'b0;
        ack_en   = 1'b1;
        rx_ready = 1'b1;
        snap = wr_dat_q.size();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_bus_quiet", m_stb_o, 0);
        end
        check("post_rst_no_write", wr_dat_q.size(), snap);
        check("post_rst_cfg_dropped", cfg_busy, 0);

        // Protocol properties gathered over the whole run.
        check("stb_stable_while_waiting", stab_bad, 0);
        check("stb_low_after_ack", gap_bad, 0);
        check("iack_only_on_reads", iack_bad, 0);
        check("iack_seen_on_reads", 32'(iack_seen > 0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
